// File: rtl/paddle_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | paddle_pkg - shared key FSM states, key indices and event codes     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package paddle_pkg;

    typedef enum logic [0:0] {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } key_state_e;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_PRESS  = 2'd1,
        EV_REPEAT = 2'd2
    } key_ev_e;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_P1_UP = 0;
    localparam int KEY_P1_DN = 1;
    localparam int KEY_P2_UP = 2;
    localparam int KEY_P2_DN = 3;

    // Press and repeat events both request one paddle step.
    function automatic logic is_move(input logic [1:0] ev);
        return ev != EV_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_debounce - synchronizer plus debounce/auto-repeat FSM per key   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module key_debounce
    import paddle_pkg::*;
#(
    parameter int DEB_N    = 3,
    parameter int REPEAT_N = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       key_n,
    output logic [1:0] evt
);

    localparam int DEB_W = (DEB_N > 1) ? $clog2(DEB_N + 1) : 1;
    localparam int REP_W = (REPEAT_N > 1) ? $clog2(REPEAT_N + 1) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_N - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_N - 1);

    localparam logic [0:0] S_RELEASED = RELEASED;
    localparam logic [0:0] S_PRESSED  = PRESSED;

    logic             sync1;
    logic             sync2;
    logic             sample;
    logic [0:0]       state;
    logic [0:0]       state_nx;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_nx;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign sample = ~sync2;

    // deb_cnt counts consecutive samples that disagree with the current state.
    always_comb begin
        state_nx = state;
        deb_nx   = deb_cnt;
        rep_nx   = rep_cnt;
        evt      = EV_NONE;
        if (tick) begin
            if (state == S_RELEASED) begin
                if (sample) begin
                    if (deb_cnt == DEB_LAST) begin
                        state_nx = S_PRESSED;
                        deb_nx   = '0;
                        rep_nx   = '0;
                        evt      = EV_PRESS;
                    end else begin
                        deb_nx = deb_cnt + 1'b1;
                    end
                end else begin
                    deb_nx = '0;
                end
            end else begin
                if (!sample) begin
                    if (deb_cnt == DEB_LAST) begin
                        state_nx = S_RELEASED;
                        deb_nx   = '0;
                    end else begin
                        deb_nx = deb_cnt + 1'b1;
                    end
                end else begin
                    deb_nx = '0;
                    if (rep_cnt == REP_LAST) begin
                        rep_nx = '0;
                        evt    = EV_REPEAT;
                    end else begin
                        rep_nx = rep_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_RELEASED;
            deb_cnt <= '0;
            rep_cnt <= '0;
        end else begin
            state   <= state_nx;
            deb_cnt <= deb_nx;
            rep_cnt <= rep_nx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | paddle_ctrl - sample-tick divider, key arbitration, paddle positions |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int TICK_DIV = 300000,
    parameter int DEB_N    = 3,
    parameter int REPEAT_N = 10,
    parameter int PAD_W    = 10,
    parameter int PAD_MIN  = 0,
    parameter int PAD_MAX  = 400,
    parameter int PAD_INIT = 200,
    parameter int STEP     = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [3:0]       key_n,
    input  logic             recenter,
    output logic             tick_o,
    output logic [PAD_W-1:0] p1_pos,
    output logic [PAD_W-1:0] p2_pos,
    output logic             p1_move,
    output logic             p2_move
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [PAD_W:0]   STEP_X   = (PAD_W + 1)'(STEP);
    localparam logic [PAD_W:0]   MIN_X    = (PAD_W + 1)'(PAD_MIN);
    localparam logic [PAD_W:0]   MAX_X    = (PAD_W + 1)'(PAD_MAX);
    localparam logic [PAD_W-1:0] INIT_P   = PAD_W'(PAD_INIT);

    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       evt [NUM_KEYS];
    logic [PAD_W-1:0] p1_nx;
    logic [PAD_W-1:0] p2_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt <= '0;
        end else if (tick_cnt == CNT_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick_o = (tick_cnt == CNT_LAST);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_keys
        key_debounce #(
            .DEB_N    (DEB_N),
            .REPEAT_N (REPEAT_N)
        ) u_key (
            .clk   (clk),
            .rstn  (rstn),
            .tick  (tick_o),
            .key_n (key_n[k]),
            .evt   (evt[k])
        );
    end

    // One extra bit keeps the subtraction from wrapping before the clamp.
    function automatic logic [PAD_W-1:0] next_pos(
        input logic [PAD_W-1:0] pos,
        input logic             up,
        input logic             dn
    );
        logic [PAD_W:0] res;
        res = {1'b0, pos};
        if (up && !dn) begin
            res = {1'b0, pos} - STEP_X;
            if (res[PAD_W] || (res < MIN_X)) begin
                res = MIN_X;
            end
        end else if (dn && !up) begin
            res = {1'b0, pos} + STEP_X;
            if (res > MAX_X) begin
                res = MAX_X;
            end
        end
        return res[PAD_W-1:0];
    endfunction

    always_comb begin
        p1_nx = next_pos(p1_pos, is_move(evt[KEY_P1_UP]), is_move(evt[KEY_P1_DN]));
        p2_nx = next_pos(p2_pos, is_move(evt[KEY_P2_UP]), is_move(evt[KEY_P2_DN]));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p1_pos  <= INIT_P;
            p2_pos  <= INIT_P;
            p1_move <= 1'b0;
            p2_move <= 1'b0;
        end else if (recenter) begin
            p1_pos  <= INIT_P;
            p2_pos  <= INIT_P;
            p1_move <= (p1_pos != INIT_P);
            p2_move <= (p2_pos != INIT_P);
        end else begin
            p1_pos  <= p1_nx;
            p2_pos  <= p2_nx;
            p1_move <= (p1_nx != p1_pos);
            p2_move <= (p2_nx != p2_pos);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for paddle_ctrl: directed scenarios plus random keys
// compared each cycle against a behavioural model.
module tb_paddle_ctrl;

    localparam int TD    = 4;
    localparam int DEB   = 2;
    localparam int REP   = 3;
    localparam int PW    = 10;
    localparam int PMIN  = 0;
    localparam int PMAX  = 40;
    localparam int PINIT = 20;
    localparam int STEP  = 8;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic          recenter = 1'b0;
    logic [3:0]    key_n    = 4'hF;
    logic          tick_o;
    logic          p1_move;
    logic          p2_move;
    logic [PW-1:0] p1_pos;
    logic [PW-1:0] p2_pos;
    logic [22:0]   dut_vec;

    int total = 0;
    int bad   = 0;

    paddle_ctrl #(
        .TICK_DIV (TD),
        .DEB_N    (DEB),
        .REPEAT_N (REP),
        .PAD_W    (PW),
        .PAD_MIN  (PMIN),
        .PAD_MAX  (PMAX),
        .PAD_INIT (PINIT),
        .STEP     (STEP)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .key_n    (key_n),
        .recenter (recenter),
        .tick_o   (tick_o),
        .p1_pos   (p1_pos),
        .p2_pos   (p2_pos),
        .p1_move  (p1_move),
        .p2_move  (p2_move)
    );

    always #5 clk = ~clk;

    assign dut_vec = {tick_o, p1_move, p2_move, p1_pos, p2_pos};

    // Behavioural model: edge count since reset, key delay line, per-key streaks.
    int m_cyc;
    int m_s1[4];
    int m_s2[4];
    int m_pr[4];
    int m_streak[4];
    int m_held[4];
    int m_pos[2];
    int m_move[2];

    task automatic model_reset();
        m_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            m_s1[k] = 1; m_s2[k] = 1; m_pr[k] = 0; m_streak[k] = 0; m_held[k] = 0;
        end
        for (int p = 0; p < 2; p++) begin
            m_pos[p] = PINIT; m_move[p] = 0;
        end
    endtask

    task automatic model_edge();
        int ev[4];
        int np;
        int up;
        int dn;
        bit t;
        if (!rstn) begin
            model_reset();
            return;
        end
        t = (m_cyc % TD) == TD - 1;
        for (int k = 0; k < 4; k++) begin
            ev[k] = 0;
            if (t) begin
                if (m_pr[k] == 0) begin
                    if (m_s2[k] == 0) begin
                        m_streak[k]++;
                        if (m_streak[k] == DEB) begin
                            m_pr[k] = 1; m_streak[k] = 0; m_held[k] = 0; ev[k] = 1;
                        end
                    end else begin
                        m_streak[k] = 0;
                    end
                end else if (m_s2[k] != 0) begin
                    m_streak[k]++;
                    if (m_streak[k] == DEB) begin
                        m_pr[k] = 0; m_streak[k] = 0;
                    end
                end else begin
                    m_streak[k] = 0;
                    m_held[k]++;
                    if (m_held[k] == REP) begin
                        m_held[k] = 0; ev[k] = 1;
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            up = ev[2*p];
            dn = ev[2*p+1];
            np = m_pos[p];
            if (recenter) np = PINIT;
            else if (up != 0 && dn == 0) np = (m_pos[p] - STEP < PMIN) ? PMIN : m_pos[p] - STEP;
            else if (dn != 0 && up == 0) np = (m_pos[p] + STEP > PMAX) ? PMAX : m_pos[p] + STEP;
            m_move[p] = (np != m_pos[p]) ? 1 : 0;
            m_pos[p]  = np;
        end
        for (int k = 0; k < 4; k++) begin
            m_s2[k] = m_s1[k];
            m_s1[k] = key_n[k] ? 1 : 0;
        end
        m_cyc++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [22:0] exp_vec();
        logic t;
        t = (m_cyc % TD) == TD - 1;
        return {t, m_move[0] != 0, m_move[1] != 0, 10'(m_pos[0]), 10'(m_pos[1])};
    endfunction

    task automatic test_reset();
        logic [22:0] rst_vec;
        rst_vec  = {3'b000, 10'd20, 10'd20};
        rstn     = 1'b0;
        key_n    = 4'hF;
        recenter = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (dut_vec !== rst_vec) begin
                bad++; $display("FAIL reset_state: got %h want %h", dut_vec, rst_vec);
            end
        end
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL reset_divider: got %h want %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_hold_down();
        int seen[$];
        int want[3] = '{28, 36, 40};
        key_n[1] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL hold_down: got %h want %h", dut_vec, exp_vec());
            end
            if (p1_move) seen.push_back(int'(p1_pos));
        end
        total++;
        if (seen.size() != 3) begin
            bad++; $display("FAIL hold_down_pulses: got %0d want 3", seen.size());
        end
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            total++;
            if (seen[i] != want[i]) begin
                bad++; $display("FAIL hold_down_pos%0d: got %0d want %0d", i, seen[i], want[i]);
            end
        end
        key_n = 4'hF;
        for (int i = 0; i < 17; i++) begin
            recenter = (i == 12);
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL hold_down_tail: got %h want %h", dut_vec, exp_vec());
            end
        end
        recenter = 1'b0;
    endtask

    task automatic test_glitch();
        int moves = 0;
        key_n[0] = 1'b0;
        for (int i = 0; i < 28; i++) begin
            if (i == 4) key_n[0] = 1'b1;
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL glitch: got %h want %h", dut_vec, exp_vec());
            end
            if (p1_move) moves++;
        end
        total++;
        if (moves != 0 || p1_pos !== 10'd20) begin
            bad++; $display("FAIL glitch_nomove: got moves=%0d pos=%0d want 0/20", moves, p1_pos);
        end
    endtask

    task automatic test_conflict();
        int moves = 0;
        key_n = 4'b1100;
        for (int i = 0; i < 76; i++) begin
            if (i == 60) key_n = 4'hF;
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL conflict: got %h want %h", dut_vec, exp_vec());
            end
            if (p1_move) moves++;
        end
        total++;
        if (moves != 0 || p1_pos !== 10'd20) begin
            bad++; $display("FAIL conflict_nomove: got moves=%0d pos=%0d want 0/20", moves, p1_pos);
        end
    endtask

    task automatic test_p2();
        int seen[$];
        int want[3] = '{12, 4, 0};
        key_n[2] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL p2_hold: got %h want %h", dut_vec, exp_vec());
            end
            if (p2_move) seen.push_back(int'(p2_pos));
        end
        total++;
        if (seen.size() != 3) begin
            bad++; $display("FAIL p2_pulses: got %0d want 3", seen.size());
        end
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            total++;
            if (seen[i] != want[i]) begin
                bad++; $display("FAIL p2_pos%0d: got %0d want %0d", i, seen[i], want[i]);
            end
        end
        // Two released ticks, re-press, release, then recenter.
        for (int i = 0; i < 49; i++) begin
            key_n[2] = !(i >= 8 && i < 32);
            recenter = (i == 48);
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL p2_repress: got %h want %h", dut_vec, exp_vec());
            end
        end
        recenter = 1'b0;
    endtask

    task automatic test_recenter();
        logic exp1;
        logic exp2;
        key_n[1] = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < int'($urandom_range(2, 9)); i++) begin
                cycle();
                total++;
                if (dut_vec !== exp_vec()) begin
                    bad++; $display("FAIL recenter_run: got %h want %h", dut_vec, exp_vec());
                end
            end
            for (int j = 0; j < 2 * TD && !tick_o; j++) cycle();
            total++;
            if (!tick_o) begin
                bad++; $display("FAIL recenter_tick_wait: got tick=0 want 1");
            end
            exp1 = (m_pos[0] != PINIT);
            exp2 = (m_pos[1] != PINIT);
            recenter = 1'b1;
            cycle();
            recenter = 1'b0;
            total++;
            if (p1_pos !== 10'd20 || p1_move !== exp1 || p2_move !== exp2) begin
                bad++; $display("FAIL recenter_load: got pos=%0d mv=%b%b want 20 mv=%b%b",
                                p1_pos, p1_move, p2_move, exp1, exp2);
            end
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL recenter_model: got %h want %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [22:0] rst_vec;
        int first = 0;
        rst_vec  = {3'b000, 10'd20, 10'd20};
        key_n[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL reset_mid_pre: got %h want %h", dut_vec, exp_vec());
            end
        end
        #1 rstn = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_vec !== rst_vec) begin
            bad++; $display("FAIL reset_mid_async: got %h want %h", dut_vec, rst_vec);
        end
        cycle();
        rstn = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL reset_mid_post: got %h want %h", dut_vec, exp_vec());
            end
            if (p1_move && first == 0) first = e;
        end
        total++;
        if (first != 2 * TD) begin
            bad++; $display("FAIL reset_mid_first_move: got edge %0d want %0d", first, 2 * TD);
        end
        key_n = 4'hF;
        for (int i = 0; i < 16; i++) begin
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL reset_mid_tail: got %h want %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int idx;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                idx = int'($urandom_range(0, 3));
                key_n[idx] = ~key_n[idx];
            end
            recenter = ($urandom_range(0, 63) == 0);
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        recenter = 1'b0;
        key_n    = 4'hF;
    endtask

    initial begin
        test_reset();
        test_hold_down();
        test_glitch();
        test_conflict();
        test_p2();
        test_recenter();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
